sample_entry: RTL
=================

Name: sample_entry

Overview:
- Front-end sample writer for the FFT core. Operators key 16-bit samples from the 8 slide switches in two byte presses: low byte first, then high byte.
- Each completed sample is stored in an N-entry buffer. When the buffer fills, the block offers it to the core through a Ready/Take/Release handshake, and the core reads it through a synchronous read port.
- Drives a 16-bit display word and a display-active flag that feed the hex display driver. Button inputs are single-cycle pulses from debouncers.

Parameters:
- N_SAMPLES, 16, buffer depth; must be a power of two, at least 2.
- ADDR_W, 4, log2(N_SAMPLES).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Sw  in  8  switch byte.
- Enter  in  1  one-cycle pulse; latch the current byte.
- Back  in  1  one-cycle pulse; discard the pending low byte, or undo the last sample.
- Clear  in  1  one-cycle pulse; empty the buffer.
- Take  in  1  one-cycle pulse from the core; lock the buffer.
- Release  in  1  one-cycle pulse from the core; free and empty the buffer.
- RdAddr  in  ADDR_W  core read address.
- RdData  out  16  mem[RdAddr], registered.
- Ready  out  1  buffer full and offered to the core.
- Count  out  ADDR_W+1  number of stored samples.
- Disp  out  16  display word, nibbles 3..0 map to SSD3..SSD0.
- ActivateSSD  out  1  display enable.

Behaviour:
- States:
  - LO: awaiting the low byte.
  - HI: low byte held, awaiting the high byte.
  - FULL: buffer full and offered to the core.
  - LOCKED: the core owns the buffer.
- Reset: state=LO, wr_ptr=0, Count=0, lo_byte=0, Ready=0, Disp=0, ActivateSSD=0, RdData=0. Memory contents are not reset.
- LO, Enter: lo_byte<=Sw; go to HI; ActivateSSD<=1.
- HI, Enter:
  - mem[wr_ptr]<={Sw,lo_byte}, wr_ptr++, Count++, last<={Sw,lo_byte}.
  - If the new Count==N_SAMPLES, go to FULL; otherwise go to LO.
- HI, Back: drop lo_byte, go to LO. Count is unchanged.
- LO, Back:
  - If Count>0: wr_ptr--, Count--.
  - If Count==0: no effect. No underflow or wrap.
- FULL, Back: wr_ptr--, Count--, Ready drops, go to LO. The undo is allowed until the core takes the buffer.
- Enter and Back in the same cycle: Enter wins, Back is ignored.
- Clear in LO, HI or FULL: Count=0, wr_ptr=0, go to LO, ActivateSSD<=0. Clear has priority over Enter and Back. Clear is ignored in LOCKED.
- FULL, Take: go to LOCKED. Take in any other state is ignored.
- LOCKED, Release: Count=0, wr_ptr=0, go to LO, ActivateSSD<=0. Release in any other state is ignored.
- LOCKED: Enter, Back and Clear are ignored. The buffer is immutable.
- Ready is registered and equals (state==FULL). It is asserted in the cycle after the write that fills the buffer.
- wr_ptr never wraps: filling the buffer moves to FULL before any further write is possible.
- Count ranges from 0 to N_SAMPLES.
- RdData:
  - Latency is 1 cycle: RdAddr sampled at edge k appears in RdData after edge k.
  - The read port is active in all states.
  - A read of the address written in the same cycle returns the old data.
- Disp is registered and updates on the edge after its inputs change:
  - LO: {8'h00, Sw}.
  - HI: {Sw, lo_byte}.
  - FULL and LOCKED: last, the most recent completed sample.
- Reset in any state, including LOCKED, returns to the reset values on the next edge. The core must treat Ready low after reset as buffer invalid.

Test Plan:
- Reset, then Sw=8'h34 Enter, Sw=8'h12 Enter -> Count=1; mem[0]=16'h1234 read back via RdAddr=0 with RdData valid one cycle later; Disp shows 16'h1234 in HI before the second press and 16'h0012 in LO after it.
- Enter 16 samples 16'h0000..16'h000F -> Ready rises the cycle after the 16th write; Count=16; a further Enter is ignored; Back -> Count=15, Ready=0, state LO.
- From FULL, Take -> LOCKED; Enter, Back and Clear pulses leave Count=16 and the memory unchanged; reading addresses 0..15 returns 16'h0000..16'h000F; Release -> Count=0, Ready=0, ActivateSSD=0.
- In HI with lo_byte=8'hAA, pulse Enter and Back together with Sw=8'h55 -> sample 16'h55AA stored and Count increments. Separately, Back alone in HI -> LO with Count unchanged; Back at Count=0 -> Count stays 0.
- With Count=5, pulse Clear and Enter in the same cycle -> Count=0 and no write; Take while in LO -> ignored, Ready stays 0.
- Assert Reset while LOCKED -> next cycle state LO, Count=0, Ready=0, Disp=0, RdData=0.

Source files
------------

// File: rtl/sample_entry.sv
// Sample entry front end: keys 16-bit samples from switch bytes,
// buffers N_SAMPLES of them and hands the full buffer to the FFT core.
module sample_entry #(
    parameter int N_SAMPLES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        Sw,
    input  logic              Enter,
    input  logic              Back,
    input  logic              Clear,
    input  logic              Take,
    input  logic              Release,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [15:0]       RdData,
    output logic              Ready,
    output logic [ADDR_W:0]   Count,
    output logic [15:0]       Disp,
    output logic              ActivateSSD
);

    typedef enum logic [1:0] {
        LO     = 2'd0,
        HI     = 2'd1,
        FULL   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(N_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        lo_byte;
    logic [15:0]       last;
    logic [15:0]       mem [N_SAMPLES];
    logic              wr_en;
    logic [15:0]       wr_data;

    // A sample is committed by the high-byte press unless Clear pre-empts it.
    always_comb begin
        wr_en   = (state == HI) && Enter && !Clear && !Reset;
        wr_data = {Sw, lo_byte};
    end

    // Sample storage; contents survive reset.
    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // Registered read port, old data on a same-cycle write.
    always_ff @(posedge Clk) begin
        if (Reset)
            RdData <= 16'h0000;
        else
            RdData <= mem[RdAddr];
    end

    // Entry FSM with registered Ready, Count, display word and enable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= LO;
            wr_ptr      <= '0;
            Count       <= '0;
            lo_byte     <= 8'h00;
            last        <= 16'h0000;
            Ready       <= 1'b0;
            Disp        <= 16'h0000;
            ActivateSSD <= 1'b0;
        end else begin
            case (state)
                LO:      Disp <= {8'h00, Sw};
                HI:      Disp <= {Sw, lo_byte};
                default: Disp <= last;
            endcase

            case (state)
                LO: begin
                    if (Clear) begin
                        Count       <= '0;
                        wr_ptr      <= '0;
                        ActivateSSD <= 1'b0;
                    end else if (Enter) begin
                        lo_byte     <= Sw;
                        state       <= HI;
                        ActivateSSD <= 1'b1;
                    end else if (Back && Count != '0) begin
                        Count  <= Count - CNT_ONE;
                        wr_ptr <= wr_ptr - PTR_ONE;
                    end
                end
                HI: begin
                    if (Clear) begin
                        Count       <= '0;
                        wr_ptr      <= '0;
                        state       <= LO;
                        ActivateSSD <= 1'b0;
                    end else if (Enter) begin
                        Count  <= Count + CNT_ONE;
                        wr_ptr <= wr_ptr + PTR_ONE;
                        last   <= wr_data;
                        if (Count == CNT_LAST) begin
                            state <= FULL;
                            Ready <= 1'b1;
                        end else begin
                            state <= LO;
                        end
                    end else if (Back) begin
                        lo_byte <= 8'h00;
                        state   <= LO;
                    end
                end
                FULL: begin
                    if (Clear) begin
                        Count       <= '0;
                        wr_ptr      <= '0;
                        state       <= LO;
                        Ready       <= 1'b0;
                        ActivateSSD <= 1'b0;
                    end else if (Take) begin
                        state <= LOCKED;
                        Ready <= 1'b0;
                    end else if (Enter) begin
                        state <= FULL;
                    end else if (Back) begin
                        Count  <= Count - CNT_ONE;
                        wr_ptr <= wr_ptr - PTR_ONE;
                        state  <= LO;
                        Ready  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (Release) begin
                        Count       <= '0;
                        wr_ptr      <= '0;
                        state       <= LO;
                        ActivateSSD <= 1'b0;
                    end
                end
                default: state <= LO;
            endcase
        end
    end

endmodule
